// File: rtl/exec_ctrl.sv
// Multi-cycle execute/write-back controller for the 8-bit RISC core, driving a 4x8 register file.
// Optional macro EXEC_SHIFT_EN builds the SHL/SHR shifter; otherwise opcodes 8/9 behave as NOP.
module exec_ctrl #(
  parameter int IMM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [1:0] rf_rd,
  output logic [1:0] rf_rs,
  input  logic [7:0] rf_dout_rd,
  input  logic [7:0] rf_dout_rs,
  output logic       rf_we,
  output logic [7:0] rf_din,
  output logic       flag_z,
  output logic       flag_c,
  output logic       retire,
  output logic       imm_err,
  output logic       halted
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IMM = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_WB       = 3'd4;
  localparam logic [2:0] S_HALT     = 3'd5;

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5, OP_NOT = 4'h6, OP_MOV = 4'h7, OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9, OP_CMP = 4'hA, OP_LDI = 4'hB, OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD, OP_HLT = 4'hF;

  localparam int            CW       = (IMM_WAIT_MAX > 1) ? $clog2(IMM_WAIT_MAX) : 1;
  localparam bit            TMO_EN   = (IMM_WAIT_MAX > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((IMM_WAIT_MAX > 0) ? IMM_WAIT_MAX - 1 : 0);

  logic [2:0]    r_state;
  logic [7:0]    r_instr, r_a, r_b, r_result;
  logic          r_wb_en, r_z, r_c, r_imm_err, r_halt_ret;
  logic [CW-1:0] r_cnt;

  logic       w_hs, w_upd, w_we, w_c;
  logic [7:0] w_res;
  logic [8:0] w_sum;

  assign w_hs = instr_valid && instr_ready;

  // LDI carries its immediate in r_b, so every opcode reads operands from r_a/r_b.
  always_comb begin
    w_res = 8'h00;
    w_c   = r_c;
    w_upd = 1'b1;
    w_we  = 1'b1;
    w_sum = 9'h000;
    case (r_instr[7:4])
      OP_ADD: begin w_sum = {1'b0, r_a} + {1'b0, r_b}; w_res = w_sum[7:0]; w_c = w_sum[8]; end
      OP_SUB, OP_CMP: begin
        w_sum = {1'b0, r_a} - {1'b0, r_b};
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_we  = (r_instr[7:4] == OP_SUB);
      end
      OP_AND: begin w_res = r_a & r_b; w_c = 1'b0; end
      OP_OR:  begin w_res = r_a | r_b; w_c = 1'b0; end
      OP_XOR: begin w_res = r_a ^ r_b; w_c = 1'b0; end
      OP_NOT: w_res = ~r_a;
      OP_MOV: w_res = r_b;
`ifdef EXEC_SHIFT_EN
      OP_SHL: begin w_res = {r_a[6:0], 1'b0}; w_c = r_a[7]; end
      OP_SHR: begin w_res = {1'b0, r_a[7:1]}; w_c = r_a[0]; end
`endif
      OP_LDI: w_res = r_b;
      OP_INC: begin w_sum = {1'b0, r_a} + 9'h001; w_res = w_sum[7:0]; w_c = w_sum[8]; end
      OP_DEC: begin w_sum = {1'b0, r_a} - 9'h001; w_res = w_sum[7:0]; w_c = w_sum[8]; end
      default: begin w_upd = 1'b0; w_we = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    r_imm_err  <= 1'b0;
    r_halt_ret <= 1'b0;
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_instr  <= 8'h00;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_result <= 8'h00;
      r_wb_en  <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_instr <= instr;
          r_cnt   <= '0;
          case (instr[7:4])
            OP_LDI:  r_state <= S_WAIT_IMM;
            OP_HLT:  begin r_state <= S_HALT; r_halt_ret <= 1'b1; end
            default: r_state <= S_READ;
          endcase
        end
        S_WAIT_IMM: begin
          if (w_hs) begin
            r_b     <= instr;
            r_state <= S_EXEC;
          end else if (TMO_EN) begin
            // Abort leaves flags and registers untouched; only the error pulse is visible.
            if (r_cnt == CNT_LAST) begin
              r_imm_err <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_READ: begin
          r_a     <= rf_dout_rd;
          r_b     <= rf_dout_rs;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_res;
          r_wb_en  <= w_we;
          if (w_upd) begin
            r_z <= (w_res == 8'h00);
            r_c <= w_c;
          end
          r_state <= S_WB;
        end
        S_WB:    r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE) || (r_state == S_WAIT_IMM);
  assign rf_rd       = r_instr[3:2];
  assign rf_rs       = r_instr[1:0];
  assign rf_we       = (r_state == S_WB) && r_wb_en;
  assign rf_din      = r_result;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign retire      = (r_state == S_WB) || r_halt_ret;
  assign imm_err     = r_imm_err;
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a behavioural 4x8 register file and IMM_WAIT_MAX=4.
module tb_exec_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready, rf_we, flag_z, flag_c, retire, imm_err, halted;
  logic [1:0] rf_rd, rf_rs;
  logic [7:0] rf_dout_rd, rf_dout_rs, rf_din;

  int n_cmp = 0;
  int n_err = 0;
  int n_we  = 0;
  int n_ret = 0;
  int n_ie  = 0;

  logic [7:0] regs [4] = '{default: 8'h00};

  exec_ctrl #(.IMM_WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_rd(rf_rd), .rf_rs(rf_rs),
    .rf_dout_rd(rf_dout_rd), .rf_dout_rs(rf_dout_rs), .rf_we(rf_we), .rf_din(rf_din),
    .flag_z(flag_z), .flag_c(flag_c), .retire(retire), .imm_err(imm_err), .halted(halted)
  );

  always #5 clk = ~clk;

  assign rf_dout_rd = regs[rf_rd];
  assign rf_dout_rs = regs[rf_rs];

  always @(posedge clk) begin
    if (rf_we) begin
      regs[rf_rd] <= rf_din;
      n_we <= n_we + 1;
    end
    if (retire)  n_ret <= n_ret + 1;
    if (imm_err) n_ie  <= n_ie + 1;
  end

  // Present one byte at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] b);
    instr_valid = 1'b1;
    instr = b;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Issue a register-operand instruction and stop at the negedge of its WB cycle.
  task automatic to_wb(input logic [7:0] b);
    issue(b);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] rd, input logic [7:0] v);
    issue({4'hB, rd, 2'b00});
    issue(v);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    instr_valid = 1'b1;
    instr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({instr_ready, rf_we, flag_z, flag_c, halted, retire, imm_err, rf_rd, rf_rs, rf_din} !== {1'b1, 6'b0, 2'd0, 2'd0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b we=%b z=%b c=%b h=%b ret=%b ie=%b din=%h", instr_ready, rf_we, flag_z, flag_c, halted, retire, imm_err, rf_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n_cmp++;
    if (instr_ready !== 1'b0) begin n_err++; $display("FAIL first_accept: instr_ready=%b want 0", instr_ready); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({retire, rf_we} !== 2'b10) begin n_err++; $display("FAIL nop_retire: ret/we=%b want 10", {retire, rf_we}); end
    @(negedge clk);
  endtask

  task automatic test_add;
    int r0;
    load(2'd1, 8'hF0);
    load(2'd2, 8'h20);
    r0 = n_ret;
    issue(8'h16);
    @(negedge clk);
    n_cmp++;
    if (rf_we !== 1'b0) begin n_err++; $display("FAIL add_early_we: rf_we=%b at N+2 want 0", rf_we); end
    @(negedge clk);
    n_cmp++;
    if ({rf_we, retire, rf_rd, rf_din, flag_c, flag_z} !== {1'b1, 1'b1, 2'd1, 8'h10, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_wb: we=%b ret=%b rd=%0d din=%h c=%b z=%b want 1 1 1 10 1 0", rf_we, retire, rf_rd, rf_din, flag_c, flag_z);
    end
    @(negedge clk);
    n_cmp++;
    if (n_ret - r0 !== 1 || retire !== 1'b0) begin n_err++; $display("FAIL add_retire_count: got %0d want 1", n_ret - r0); end
  endtask

  task automatic test_ldi;
    issue(8'hBC);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b1) begin n_err++; $display("FAIL ldi_wait_ready: instr_ready=%b want 1", instr_ready); end
    issue(8'h00);
    @(negedge clk);
    n_cmp++;
    if ({rf_we, rf_rd, rf_din, flag_z, flag_c} !== {1'b1, 2'd3, 8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ldi_wb: we=%b rd=%0d din=%h z=%b c=%b want 1 3 00 1 1", rf_we, rf_rd, rf_din, flag_z, flag_c);
    end
    @(negedge clk);
  endtask

  task automatic test_imm_timeout;
    int w0;
    w0 = n_we;
    issue(8'hB0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({imm_err, instr_ready} !== 2'b01) begin n_err++; $display("FAIL tmo_wait_%0d: ie/rdy=%b want 01", i, {imm_err, instr_ready}); end
      @(negedge clk);
    end
    n_cmp++;
    if ({imm_err, instr_ready} !== 2'b11) begin n_err++; $display("FAIL tmo_pulse: ie/rdy=%b want 11", {imm_err, instr_ready}); end
    @(negedge clk);
    n_cmp++;
    if ({imm_err, flag_z, flag_c} !== 3'b011 || n_we != w0 || n_ie != 1) begin
      n_err++;
      $display("FAIL tmo_after: ie=%b z=%b c=%b writes=%0d errs=%0d want 0 1 1 0 1", imm_err, flag_z, flag_c, n_we - w0, n_ie);
    end
  endtask

  task automatic test_cmp_shift;
    load(2'd0, 8'h05);
    load(2'd1, 8'h09);
    to_wb(8'h30);
    n_cmp++;
    if ({rf_we, rf_din, flag_c, flag_z} !== {1'b1, 8'h05, 2'b00}) begin n_err++; $display("FAIL and_wb: we=%b din=%h c=%b z=%b want 1 05 0 0", rf_we, rf_din, flag_c, flag_z); end
    @(negedge clk);
    to_wb(8'hA1);
    n_cmp++;
    if ({rf_we, retire, flag_c, flag_z} !== 4'b0110) begin n_err++; $display("FAIL cmp_wb: we/ret/c/z=%b want 0110", {rf_we, retire, flag_c, flag_z}); end
    @(negedge clk);
    to_wb(8'h25);
    n_cmp++;
    if ({rf_we, rf_din, flag_z, flag_c} !== {1'b1, 8'h00, 2'b10}) begin n_err++; $display("FAIL sub_same_wb: we=%b din=%h z=%b c=%b want 1 00 1 0", rf_we, rf_din, flag_z, flag_c); end
    @(negedge clk);
    to_wb(8'h90);
`ifdef EXEC_SHIFT_EN
    n_cmp++;
    if ({rf_we, rf_rd, rf_din, flag_c, flag_z} !== {1'b1, 2'd0, 8'h02, 2'b10}) begin n_err++; $display("FAIL shr_wb: we=%b rd=%0d din=%h c=%b z=%b want 1 0 02 1 0", rf_we, rf_rd, rf_din, flag_c, flag_z); end
`else
    n_cmp++;
    if ({rf_we, retire, flag_z, flag_c} !== 4'b0110) begin n_err++; $display("FAIL shr_nop_wb: we/ret/z/c=%b want 0110", {rf_we, retire, flag_z, flag_c}); end
`endif
    @(negedge clk);
    to_wb(8'hD4);
    n_cmp++;
    if ({rf_we, rf_din, flag_c, flag_z} !== {1'b1, 8'hFF, 2'b10}) begin n_err++; $display("FAIL dec_wrap: we=%b din=%h c=%b z=%b want 1 ff 1 0", rf_we, rf_din, flag_c, flag_z); end
    @(negedge clk);
    to_wb(8'hC4);
    n_cmp++;
    if ({rf_we, rf_din, flag_c, flag_z} !== {1'b1, 8'h00, 2'b11}) begin n_err++; $display("FAIL inc_wrap: we=%b din=%h c=%b z=%b want 1 00 1 1", rf_we, rf_din, flag_c, flag_z); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int w0;
    w0 = n_we;
    issue(8'h16);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({rf_we, retire, instr_ready, flag_z, flag_c} !== 5'b00100 || n_we != w0) begin
      n_err++;
      $display("FAIL mid_reset: we/ret/rdy/z/c=%b writes=%0d want 00100 0", {rf_we, retire, instr_ready, flag_z, flag_c}, n_we - w0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat;
    int r0, w0;
    pat = 8'b1000_1000;
    r0 = n_ret;
    w0 = n_we;
    instr_valid = 1'b1;
    instr = 8'h78;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (instr_ready !== pat[i]) begin n_err++; $display("FAIL b2b_ready_%0d: instr_ready=%b want %b", i, instr_ready, pat[i]); end
    end
    instr = 8'hF0;
    @(negedge clk);
    instr = 8'h16;
    n_cmp++;
    if ({halted, retire, instr_ready} !== 3'b110) begin n_err++; $display("FAIL halt_enter: h/ret/rdy=%b want 110", {halted, retire, instr_ready}); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({halted, retire, instr_ready} !== 3'b100 || n_ret - r0 != 3 || n_we - w0 != 2) begin
      n_err++;
      $display("FAIL halt_hold: h/ret/rdy=%b retires=%0d writes=%0d want 100 3 2", {halted, retire, instr_ready}, n_ret - r0, n_we - w0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_valid = 1'b0;
    n_cmp++;
    if ({halted, instr_ready, rf_we} !== 3'b010) begin n_err++; $display("FAIL halt_reset: h/rdy/we=%b want 010", {halted, instr_ready, rf_we}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ldi();
    test_imm_timeout();
    test_cmp_shift();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
